// File: rtl/r3_trace_shadow.sv
// r3_trace_shadow: passive shadow of one core register rebuilt from its writeback retire trace
module r3_trace_shadow #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int TRACK_REG = 3,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
  parameter int CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      valid,
  input  logic                      we,
  input  logic [REG_ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0]     data,
  output logic [DATA_WIDTH-1:0]     r3,
  output logic [DATA_WIDTH-1:0]     r3_fwd,
  output logic                      r3_update,
  output logic                      r3_written,
  output logic [CNT_WIDTH-1:0]      write_count
);
  logic hit;
  logic [DATA_WIDTH-1:0] r3_d, r3_q;
  logic update_d, update_q, written_d, written_q;
  logic [CNT_WIDTH-1:0] cnt_d, cnt_q;
  // valid gates the compare first so X on addr/data while idle cannot leak into state
  assign hit = valid && we && (addr == REG_ADDR_WIDTH'(TRACK_REG));
  always_comb begin
    r3_d      = hit ? data : r3_q;
    update_d  = hit;
    written_d = written_q | hit;
    cnt_d     = (hit && !(&cnt_q)) ? cnt_q + CNT_WIDTH'(1) : cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r3_q      <= RESET_VALUE;
      update_q  <= 1'b0;
      written_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      r3_q      <= r3_d;
      update_q  <= update_d;
      written_q <= written_d;
      cnt_q     <= cnt_d;
    end
  end
  assign r3          = r3_q;
  assign r3_fwd      = hit ? data : r3_q;
  assign r3_update   = update_q;
  assign r3_written  = written_q;
  assign write_count = cnt_q;
endmodule

// File: tb/tb_r3_trace_shadow.sv
// tb_r3_trace_shadow: scoreboard bench; second instance uses a 4-bit counter for saturation
module tb_r3_trace_shadow;
  logic clk = 1'b0, rst_n = 1'b0, valid = 1'b0, we = 1'b0;
  logic [4:0] addr = '0;
  logic [31:0] data = '0;
  logic [31:0] r3, r3_fwd, r3_s, r3_fwd_s;
  logic upd, wr, upd_s, wr_s;
  logic [15:0] cnt;
  logic [3:0] cnt_s;
  int n_vec = 0, n_bad = 0;
  logic [31:0] m_r3 = '0;
  logic m_wr = 1'b0;
  logic [15:0] m_cnt = '0;
  logic [3:0] m_cnt_s = '0;
  typedef struct { logic [31:0] r3; logic upd, wr; logic [15:0] cnt; logic [3:0] cnt_s; } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  r3_trace_shadow dut (.clk(clk), .rst_n(rst_n), .valid(valid), .we(we), .addr(addr), .data(data),
    .r3(r3), .r3_fwd(r3_fwd), .r3_update(upd), .r3_written(wr), .write_count(cnt));
  r3_trace_shadow #(.CNT_WIDTH(4)) dut_s (.clk(clk), .rst_n(rst_n), .valid(valid), .we(we), .addr(addr),
    .data(data), .r3(r3_s), .r3_fwd(r3_fwd_s), .r3_update(upd_s), .r3_written(wr_s), .write_count(cnt_s));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_r3"}, r3, m_r3);
    chk({tag, "_wr"}, {31'd0, wr}, {31'd0, m_wr});
    chk({tag, "_cnt"}, {16'd0, cnt}, {16'd0, m_cnt});
    chk({tag, "_upd"}, {31'd0, upd}, 32'd0);
    chk({tag, "_cnt_s"}, {28'd0, cnt_s}, {28'd0, m_cnt_s});
  endtask

  task automatic drive(input logic v, input logic w, input logic [4:0] a, input logic [31:0] d);
    exp_t e;
    logic hit;
    valid = v; we = w; addr = a; data = d;
    hit = (v === 1'b1) && (w === 1'b1) && (a === 5'd3);
    #1;
    chk("fwd", r3_fwd, hit ? d : m_r3);
    if (hit) begin
      m_r3 = d;
      m_wr = 1'b1;
      if (m_cnt != 16'hffff) m_cnt++;
      if (m_cnt_s != 4'hf) m_cnt_s++;
    end
    sb.push_back('{m_r3, hit, m_wr, m_cnt, m_cnt_s});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("r3", r3, e.r3);
    chk("r3_s", r3_s, e.r3);
    chk("upd", {31'd0, upd}, {31'd0, e.upd});
    chk("wr", {31'd0, wr}, {31'd0, e.wr});
    chk("cnt", {16'd0, cnt}, {16'd0, e.cnt});
    chk("cnt_s", {28'd0, cnt_s}, {28'd0, e.cnt_s});
  endtask

  initial begin
    #3;
    chk_state("rst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 0, 0);
    drive(1, 1, 4, 32'd1);
    drive(1, 0, 3, 32'd2);
    drive(0, 1, 3, 32'd3);
    drive(0, 1'bx, 5'bx, 32'bx);
    drive(1, 1, 0, 32'd9);
    drive(1, 1, 3, 32'hdeadbeef);
    drive(0, 0, 0, 0);
    for (int i = 1; i <= 3; i++) drive(1, 1, 3, i);
    drive(0, 0, 0, 0);
    for (int i = 0; i < 20; i++) drive(1, 1, 3, 32'h100 + i);
    drive(1, 1, 3, 32'h55);
    #2;
    rst_n = 1'b0;
    #1;
    m_r3 = '0; m_wr = 1'b0; m_cnt = '0; m_cnt_s = '0;
    chk_state("arst");
    valid = 1'b1; we = 1'b1; addr = 5'd3; data = 32'h77;
    @(posedge clk);
    #1;
    chk_state("in_rst");
    valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 1, 3, 32'h99);
    drive(0, 0, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
